// File: rtl/mantissa_divider.sv
// ---------------------------------------------------------------------------
// mantissa_divider
//
// Iterative restoring divider for floating-point significands. Produces
// floor(mant_a * 2^47 / mant_b) as a 48-bit quotient aligned to the mantissa
// multiplier's product format, so the normalizer treats MUL and DIV results
// identically (leading one at bit 47 or bit 46 for normalized operands).
// The exponent path is expected to subtract 1 from the biased difference; the
// normalizer's +1 on a bit-47 leading one restores it.
//
// Parameters:
//   BITS_PER_CYCLE  quotient bits retired per RUN cycle (1, 2, 3, 4 or 6)
//
// Ports:
//   clk           rising-edge clock
//   arst_n        synchronous active-low reset (aborts any operation)
//   en            stage enable; 0 freezes all state and outputs
//   start         division request, sampled in IDLE/DONE when en=1
//   mant_a        dividend significand {1, frac[22:0]}
//   mant_b        divisor significand  {1, frac[22:0]}
//   busy          high while iterating
//   done          result valid, one cycle per operation (held while stalled)
//   mantissa_div  48-bit quotient to the normalizer
//   div_zero      mant_b was zero for the current result
//   sticky        (DIV_STICKY_EN only) final remainder was non-zero
//
// Optional feature macro: DIV_STICKY_EN adds the sticky output.
// ---------------------------------------------------------------------------
module mantissa_divider #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        en,
    input  logic        start,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        busy,
    output logic        done,
    output logic [47:0] mantissa_div,
    output logic        div_zero
`ifdef DIV_STICKY_EN
    ,
    output logic        sticky
`endif
);

    localparam int unsigned ITERS = 48 / BITS_PER_CYCLE;

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 3 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 6)) begin : g_bad_bpc
        $error("mantissa_divider: BITS_PER_CYCLE must be 1, 2, 3, 4 or 6");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [23:0] dvsr_q, dvsr_d;
    logic [47:0] quo_q, quo_d;
    logic        sat_q, sat_d;
    logic [47:0] mant_q, mant_d;
    logic        dz_q, dz_d;
`ifdef DIV_STICKY_EN
    logic        stk_q, stk_d;
`endif

    logic [24:0]               rem_step;
    logic [BITS_PER_CYCLE-1:0] bits_step;
    logic [47:0]               quo_next;

    // Unrolled restoring steps for one RUN cycle. The partial remainder is
    // kept pre-shifted: compare, conditionally subtract, then double. Since
    // it stays below 2*divisor it always fits in 25 bits.
    always_comb begin
        rem_step  = rem_q;
        bits_step = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_step >= {1'b0, dvsr_q}) begin
                rem_step = rem_step - {1'b0, dvsr_q};
                bits_step[BITS_PER_CYCLE-1-i] = 1'b1;
            end
            rem_step = {rem_step[23:0], 1'b0};
        end
        quo_next = {quo_q[47-BITS_PER_CYCLE:0], bits_step};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        sat_d   = sat_q;
        mant_d  = mant_q;
        dz_d    = dz_q;
`ifdef DIV_STICKY_EN
        stk_d   = stk_q;
`endif
        if (en) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (mant_b == '0) begin
                            state_d = DONE;
                            mant_d  = '1;
                            dz_d    = 1'b1;
`ifdef DIV_STICKY_EN
                            stk_d   = 1'b0;
`endif
                        end else begin
                            state_d = RUN;
                            cnt_d   = 6'(ITERS);
                            rem_d   = {1'b0, mant_a};
                            dvsr_d  = mant_b;
                            quo_d   = '0;
                            // a >= 2b means the quotient needs more than 48
                            // bits; the result clamps to all ones.
                            sat_d   = ({1'b0, mant_a} >= {mant_b, 1'b0});
                        end
                    end else if (state_q == DONE) begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    rem_d = rem_step;
                    quo_d = quo_next;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = DONE;
                        mant_d  = sat_q ? '1 : quo_next;
                        dz_d    = 1'b0;
`ifdef DIV_STICKY_EN
                        stk_d   = sat_q | (rem_step != '0);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            sat_q   <= 1'b0;
            mant_q  <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_STICKY_EN
            stk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            sat_q   <= sat_d;
            mant_q  <= mant_d;
            dz_q    <= dz_d;
`ifdef DIV_STICKY_EN
            stk_q   <= stk_d;
`endif
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign mantissa_div = mant_q;
    assign div_zero     = dz_q;
`ifdef DIV_STICKY_EN
    assign sticky       = stk_q;
`endif

endmodule

// File: tb/tb_mantissa_divider.sv
// ---------------------------------------------------------------------------
// tb_mantissa_divider
//
// Drives two divider instances (BITS_PER_CYCLE=1 and 4) with shared inputs.
// A behavioural model computes each result with plain wide division and
// tracks the start/busy/done timing; every cycle the outputs of both
// instances are compared with it. Directed vectors add literal expectations
// for results, latencies, stalls, back-to-back operation and reset abort.
// ---------------------------------------------------------------------------
module tb_mantissa_divider;

    logic        clk = 1'b0;
    logic        arst_n, en, start;
    logic [23:0] mant_a, mant_b;
    logic        busy1, done1, dz1, busy4, done4, dz4;
    logic [47:0] md1, md4;
`ifdef DIV_STICKY_EN
    logic        stk1, stk4;
`endif
    logic        cmp_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mantissa_divider #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .arst_n(arst_n), .en(en), .start(start),
        .mant_a(mant_a), .mant_b(mant_b),
        .busy(busy1), .done(done1), .mantissa_div(md1), .div_zero(dz1)
`ifdef DIV_STICKY_EN
        , .sticky(stk1)
`endif
    );

    mantissa_divider #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .en(en), .start(start),
        .mant_a(mant_a), .mant_b(mant_b),
        .busy(busy4), .done(done4), .mantissa_div(md4), .div_zero(dz4)
`ifdef DIV_STICKY_EN
        , .sticky(stk4)
`endif
    );

    // ---------------- behavioural model ----------------
    function automatic logic [47:0] ref_quo(input logic [23:0] a, input logic [23:0] b);
        logic [71:0] num, q;
        num = {1'b0, a, 47'b0};
        q   = num / {48'b0, b};
        if (q[71:48] != '0) return '1;
        return q[47:0];
    endfunction

`ifdef DIV_STICKY_EN
    function automatic logic ref_inexact(input logic [23:0] a, input logic [23:0] b);
        logic [71:0] num, q, r;
        num = {1'b0, a, 47'b0};
        q   = num / {48'b0, b};
        r   = num % {48'b0, b};
        return (q[71:48] != '0) || (r != '0);
    endfunction
    logic m_stk  [2];
    logic m_pstk [2];
`endif

    int          m_phase [2];   // 0 idle, 1 running, 2 result valid
    int          m_left  [2];
    logic [47:0] m_mant  [2];
    logic [47:0] m_pend  [2];
    logic        m_dz    [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!arst_n) begin
                m_phase[k] <= 0;
                m_mant[k]  <= '0;
                m_dz[k]    <= 1'b0;
`ifdef DIV_STICKY_EN
                m_stk[k]   <= 1'b0;
`endif
            end else if (en) begin
                if (m_phase[k] != 1 && start) begin
                    if (mant_b == '0) begin
                        m_phase[k] <= 2;
                        m_mant[k]  <= '1;
                        m_dz[k]    <= 1'b1;
`ifdef DIV_STICKY_EN
                        m_stk[k]   <= 1'b0;
`endif
                    end else begin
                        m_phase[k] <= 1;
                        m_left[k]  <= (k == 0) ? 48 : 12;
                        m_pend[k]  <= ref_quo(mant_a, mant_b);
`ifdef DIV_STICKY_EN
                        m_pstk[k]  <= ref_inexact(mant_a, mant_b);
`endif
                    end
                end else if (m_phase[k] == 1) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_phase[k] <= 2;
                        m_mant[k]  <= m_pend[k];
                        m_dz[k]    <= 1'b0;
`ifdef DIV_STICKY_EN
                        m_stk[k]   <= m_pstk[k];
`endif
                    end
                end else if (m_phase[k] == 2) begin
                    m_phase[k] <= 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("busy_bpc1", 48'(busy1), 48'(m_phase[0] == 1));
        check("done_bpc1", 48'(done1), 48'(m_phase[0] == 2));
        check("mant_bpc1", md1, m_mant[0]);
        check("dz_bpc1",   48'(dz1), 48'(m_dz[0]));
        check("busy_bpc4", 48'(busy4), 48'(m_phase[1] == 1));
        check("done_bpc4", 48'(done4), 48'(m_phase[1] == 2));
        check("mant_bpc4", md4, m_mant[1]);
        check("dz_bpc4",   48'(dz4), 48'(m_dz[1]));
`ifdef DIV_STICKY_EN
        check("sticky_bpc1", 48'(stk1), 48'(m_stk[0]));
        check("sticky_bpc4", 48'(stk4), 48'(m_stk[1]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cmp_en) compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Issue a start at the next edge, then scramble the operand inputs.
    task automatic pulse_start(input logic [23:0] a, input logic [23:0] b);
        mant_a = a;
        mant_b = b;
        start  = 1'b1;
        en     = 1'b1;
        tick();
        start  = 1'b0;
        mant_a = 24'h9ABCDE;
        mant_b = 24'hF00001;
    endtask

    // Cycle c = cycle following edge E_c after the accepting edge E0.
    task automatic wait_done(input int stall_at, input int stall_len, input int extra_at,
                             output int lat1, output int lat4, output int busy_cnt,
                             output logic [47:0] q1, output logic [47:0] q4,
                             output logic z1, output logic z4);
        lat1 = -1; lat4 = -1; busy_cnt = 0;
        q1 = '0; q4 = '0; z1 = 1'b0; z4 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (busy1) busy_cnt++;
            if (done4 && lat4 < 0) begin lat4 = c; q4 = md4; z4 = dz4; end
            if (done1 && lat1 < 0) begin lat1 = c; q1 = md1; z1 = dz1; end
            if (lat1 >= 0 && lat4 >= 0) break;
            en    = !(c >= stall_at && c < stall_at + stall_len);
            start = (c == extra_at) || (c == extra_at + 9);
            tick();
        end
        en = 1'b1;
        start = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [23:0] a, input logic [23:0] b,
                           input logic [47:0] exp_q, input logic exp_stk);
        int l1, l4, bc;
        logic [47:0] q1, q4;
        logic z1, z4;
        pulse_start(a, b);
        wait_done(1000, 0, 1000, l1, l4, bc, q1, q4, z1, z4);
        check({name, "_lat1"}, 48'(l1), 48'd48);
        check({name, "_lat4"}, 48'(l4), 48'd12);
        check({name, "_busy_cycles"}, 48'(bc), 48'd48);
        check({name, "_q1"}, q1, exp_q);
        check({name, "_q4"}, q4, exp_q);
        check({name, "_dz"}, 48'(z1), 48'd0);
`ifdef DIV_STICKY_EN
        check({name, "_sticky1"}, 48'(stk1), 48'(exp_stk));
        check({name, "_sticky4"}, 48'(stk4), 48'(exp_stk));
`else
        if (exp_stk === 1'bx) $display("note: sticky expectation unknown for %s", name);
`endif
        idle(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int l1, l4, bc, dcount;
        logic [47:0] q1, q4;
        logic z1, z4;

        arst_n = 1'b0; en = 1'b1; start = 1'b0; mant_a = '0; mant_b = '0;
        tick();
        tick();
        arst_n = 1'b1;
        cmp_en = 1'b1;
        check("rst_busy", 48'(busy1), 48'd0);
        check("rst_done", 48'(done1), 48'd0);
        check("rst_mant", md1, 48'd0);
        check("rst_dz",   48'(dz1), 48'd0);

        run_vec("one_by_one",   24'h800000, 24'h800000, 48'h8000_0000_0000, 1'b0);
        run_vec("c_by_8",       24'hC00000, 24'h800000, 48'hC000_0000_0000, 1'b0);
        run_vec("8_by_c",       24'h800000, 24'hC00000, 48'h5555_5555_5555, 1'b1);
        run_vec("max_by_min",   24'hFFFFFF, 24'h800000, 48'hFFFF_FF00_0000, 1'b0);
        run_vec("max_by_max",   24'hFFFFFF, 24'hFFFFFF, 48'h8000_0000_0000, 1'b0);
        run_vec("min_by_max",   24'h800000, 24'hFFFFFF, 48'h4000_0040_0000, 1'b1);
        run_vec("unnorm_1_by_3", 24'h000001, 24'h000003, 48'h2AAA_AAAA_AAAA, 1'b1);

        // divide by zero, then a valid start accepted in the DONE cycle
        pulse_start(24'h123456, 24'h000000);
        wait_done(1000, 0, 1000, l1, l4, bc, q1, q4, z1, z4);
        check("dz_lat1", 48'(l1), 48'd0);
        check("dz_lat4", 48'(l4), 48'd0);
        check("dz_q1",   q1, 48'hFFFF_FFFF_FFFF);
        check("dz_flag1", 48'(z1), 48'd1);
        check("dz_flag4", 48'(z4), 48'd1);
`ifdef DIV_STICKY_EN
        check("dz_sticky", 48'(stk1), 48'd0);
`endif
        pulse_start(24'h800000, 24'h800000);
        check("b2b_busy", 48'(busy1), 48'd1);
        check("b2b_done", 48'(done1), 48'd0);
        check("b2b_dz_held", 48'(dz1), 48'd1);
        check("b2b_mant_held", md1, 48'hFFFF_FFFF_FFFF);
        wait_done(1000, 0, 1000, l1, l4, bc, q1, q4, z1, z4);
        check("b2b_lat1", 48'(l1), 48'd48);
        check("b2b_q1", q1, 48'h8000_0000_0000);
        check("b2b_dz_clear", 48'(z1), 48'd0);
        idle(2);

        // 5-cycle stall mid-run plus start pulses while running
        pulse_start(24'hC00000, 24'h800000);
        wait_done(10, 5, 20, l1, l4, bc, q1, q4, z1, z4);
        check("stall_lat1", 48'(l1), 48'd53);
        check("stall_busy_cycles", 48'(bc), 48'd53);
        check("stall_q1", q1, 48'hC000_0000_0000);
        check("stall_dz", 48'(z1), 48'd0);
        idle(3);

        // reset at edge E20 of a run (with en low), no done afterwards
        pulse_start(24'h800000, 24'hC00000);
        idle(19);
        arst_n = 1'b0;
        en = 1'b0;
        tick();
        arst_n = 1'b1;
        en = 1'b1;
        check("abort_busy", 48'(busy1), 48'd0);
        check("abort_done", 48'(done1), 48'd0);
        check("abort_mant", md1, 48'd0);
        check("abort_mant4", md4, 48'd0);
        dcount = 0;
        for (int c = 0; c < 60; c++) begin
            if (done1) dcount++;
            tick();
        end
        check("abort_no_done", 48'(dcount), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
